// File: rtl/spi_word_tx.sv
// SPI mode-0 master: serialises one 18-bit word per frame, MSB first, sclk half-period = CLK_DIV clk cycles.
// Define SPI_WORD_TX_QUEUE_EN to add a one-entry holding register so a frame can follow with no IDLE cycle.
module spi_word_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi
);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} state_t;

  localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'd17;

  state_t      state, state_n;
  logic [7:0]  ph_cnt, ph_cnt_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [17:0] shift_q, shift_n;
  logic        accept, phase_end, frame_on_n, done_n, ready_n;
`ifdef SPI_WORD_TX_QUEUE_EN
  logic [17:0] hold_q, hold_n;
  logic        hold_full, hold_full_n;
`endif

  assign accept     = tx_valid && tx_ready;
  assign phase_end  = (ph_cnt == PH_LAST);
  assign frame_on_n = (state_n == LEAD) || (state_n == HIGH) || (state_n == LOW);

  always_comb begin
    state_n   = state;
    ph_cnt_n  = (state == IDLE || phase_end) ? 8'd0 : ph_cnt + 8'd1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_q;
    done_n    = 1'b0;
`ifdef SPI_WORD_TX_QUEUE_EN
    hold_n      = hold_q;
    hold_full_n = hold_full;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = LEAD;
          shift_n   = tx_data;
          bit_cnt_n = '0;
        end
      end
      LEAD: if (phase_end) state_n = HIGH;
      HIGH: begin
        // The last bit is not shifted out so mosi holds bit 0 through the trailing LOW.
        if (phase_end) begin
          state_n = LOW;
          if (bit_cnt != BIT_LAST) shift_n = {shift_q[16:0], 1'b0};
        end
      end
      LOW: begin
        if (phase_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = GAP;
            done_n  = 1'b1;
          end else begin
            state_n   = HIGH;
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
      end
      GAP:     if (phase_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef SPI_WORD_TX_QUEUE_EN
    if (accept && state != IDLE) begin
      hold_n      = tx_data;
      hold_full_n = 1'b1;
    end
    // A stored word launches straight from the end of GAP, or from IDLE if it arrived in GAP's last cycle.
    if (hold_full && (state == IDLE || (state == GAP && phase_end))) begin
      state_n     = LEAD;
      shift_n     = hold_q;
      bit_cnt_n   = '0;
      hold_full_n = 1'b0;
    end
    ready_n = !hold_full_n;
`else
    ready_n = (state_n == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
`ifdef SPI_WORD_TX_QUEUE_EN
      hold_full <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      ph_cnt   <= ph_cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx_ready <= ready_n;
      tx_done  <= done_n;
      sclk     <= (state_n == HIGH);
      cs_n     <= !frame_on_n;
      mosi     <= frame_on_n ? shift_n[17] : 1'b0;
`ifdef SPI_WORD_TX_QUEUE_EN
      hold_full <= hold_full_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_n;
`ifdef SPI_WORD_TX_QUEUE_EN
    hold_q  <= hold_n;
`endif
  end

endmodule
